// File: rtl/tap7_mac.sv
// tap7_mac: 7-tap signed MAC on line-buffer taps, 3-stage pipeline gated by line-fill tracking.
// Optional Pix_Out/Pix_Valid clamp stage when TAP7_PIXOUT_EN is defined.
module tap7_mac #(
    parameter int IMG_Width = 224,
    parameter int Datawidth = 8,
    parameter int CoefWidth = 8
`ifdef TAP7_PIXOUT_EN
    ,
    parameter int Shift = 0
`endif
) (
    input  logic                               CLK,
    input  logic                               CLR,
    input  logic                               WE,
    input  logic [Datawidth-1:0]               Tap0,
    input  logic [Datawidth-1:0]               Tap1,
    input  logic [Datawidth-1:0]               Tap2,
    input  logic [Datawidth-1:0]               Tap3,
    input  logic [Datawidth-1:0]               Tap4,
    input  logic [Datawidth-1:0]               Tap5,
    input  logic [Datawidth-1:0]               Tap6,
    input  logic                               Frame_Start,
    input  logic                               Coef_WE,
    input  logic [2:0]                         Coef_Addr,
    input  logic [CoefWidth-1:0]               Coef_Data,
    output logic [Datawidth+CoefWidth+3:0]     Sum,
    output logic                               Out_Valid,
    output logic                               Fill_Done
`ifdef TAP7_PIXOUT_EN
    ,
    output logic [Datawidth-1:0]               Pix_Out,
    output logic                               Pix_Valid
`endif
);

    localparam int PW   = Datawidth + CoefWidth + 1;
    localparam int SW   = Datawidth + CoefWidth + 4;
    localparam int CLOG = $clog2(IMG_Width + 1);
    localparam int CW   = (CLOG > 9) ? CLOG : 9;
    localparam logic [CW-1:0] FULL = CW'(IMG_Width);

    logic [CW-1:0]                count, count_nxt;
    logic                         cap_en, v1, v2;
    logic [Datawidth-1:0]         taps_in [7];
    logic [Datawidth-1:0]         tap_q   [7];
    logic signed [CoefWidth-1:0]  coef    [7];
    logic signed [PW-1:0]         prod_c  [7];
    logic signed [PW-1:0]         prod_q  [7];
    logic signed [SW-1:0]         sum_c;

    assign taps_in[0] = Tap0;
    assign taps_in[1] = Tap1;
    assign taps_in[2] = Tap2;
    assign taps_in[3] = Tap3;
    assign taps_in[4] = Tap4;
    assign taps_in[5] = Tap5;
    assign taps_in[6] = Tap6;

    // Frame_Start clears first, so a coincident WE still counts as the first pixel.
    always_comb begin
        count_nxt = Frame_Start ? '0 : count;
        if (WE && (count_nxt != FULL))
            count_nxt = count_nxt + CW'(1);
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            count     <= '0;
            Fill_Done <= 1'b0;
            cap_en    <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            Out_Valid <= 1'b0;
        end else begin
            count     <= count_nxt;
            Fill_Done <= (count_nxt == FULL);
            cap_en    <= WE && (count_nxt == FULL);
            v1        <= Frame_Start ? 1'b0 : cap_en;
            v2        <= Frame_Start ? 1'b0 : v1;
            Out_Valid <= Frame_Start ? 1'b0 : v2;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int unsigned i = 0; i < 7; i++)
                coef[i] <= '0;
        end else if (Coef_WE) begin
            for (int unsigned i = 0; i < 7; i++)
                if (Coef_Addr == 3'(i))
                    coef[i] <= $signed(Coef_Data);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 7; i++)
            prod_c[i] = PW'($signed({1'b0, tap_q[i]})) * PW'(coef[i]);
    end

    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < 7; i++)
            sum_c = sum_c + SW'(prod_q[i]);
    end

    // Sum only moves with a surviving valid, so it holds whenever Out_Valid stays low.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int unsigned i = 0; i < 7; i++) begin
                tap_q[i]  <= '0;
                prod_q[i] <= '0;
            end
            Sum <= '0;
        end else begin
            if (cap_en)
                tap_q <= taps_in;
            if (v1)
                prod_q <= prod_c;
            if (v2 && !Frame_Start)
                Sum <= sum_c;
        end
    end

`ifdef TAP7_PIXOUT_EN
    localparam logic signed [SW-1:0] PIX_MAX = SW'((2 ** Datawidth) - 1);
    logic signed [SW-1:0] shifted;

    assign shifted = $signed(Sum) >>> Shift;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            Pix_Out   <= '0;
            Pix_Valid <= 1'b0;
        end else begin
            Pix_Valid <= Out_Valid;
            if (shifted[SW-1])
                Pix_Out <= '0;
            else if (shifted > PIX_MAX)
                Pix_Out <= '1;
            else
                Pix_Out <= shifted[Datawidth-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_tap7_mac.sv
// Randomized self-checking bench for tap7_mac against a queue-based behavioural model.
// Define TAP7_PIXOUT_EN to also check the clamped pixel output (Shift=2).
module tb_tap7_mac;

    localparam int IMG   = 224;
    localparam int SHIFT = 2;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        WE = 1'b0;
    logic [7:0]  Tap0 = '0, Tap1 = '0, Tap2 = '0, Tap3 = '0, Tap4 = '0, Tap5 = '0, Tap6 = '0;
    logic        Frame_Start = 1'b0;
    logic        Coef_WE = 1'b0;
    logic [2:0]  Coef_Addr = '0;
    logic [7:0]  Coef_Data = '0;
    logic [19:0] Sum;
    logic        Out_Valid;
    logic        Fill_Done;
`ifdef TAP7_PIXOUT_EN
    logic [7:0]  Pix_Out;
    logic        Pix_Valid;
`endif

    tap7_mac #(
        .IMG_Width (IMG),
        .Datawidth (8),
        .CoefWidth (8)
`ifdef TAP7_PIXOUT_EN
        ,
        .Shift     (SHIFT)
`endif
    ) dut (
        .CLK         (CLK),
        .CLR         (CLR),
        .WE          (WE),
        .Tap0        (Tap0),
        .Tap1        (Tap1),
        .Tap2        (Tap2),
        .Tap3        (Tap3),
        .Tap4        (Tap4),
        .Tap5        (Tap5),
        .Tap6        (Tap6),
        .Frame_Start (Frame_Start),
        .Coef_WE     (Coef_WE),
        .Coef_Addr   (Coef_Addr),
        .Coef_Data   (Coef_Data),
        .Sum         (Sum),
        .Out_Valid   (Out_Valid),
        .Fill_Done   (Fill_Done)
`ifdef TAP7_PIXOUT_EN
        ,
        .Pix_Out     (Pix_Out),
        .Pix_Valid   (Pix_Valid)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int cnt;
    int mcoef [7];
    int taps  [7];
    int fixed_tap = -1;
    int edge_n = 0;
    int last_sum = 0;
    int prev_v = 0;
    int prev_sum = 0;
    int ovs = 0;
    int dueq[$];
    int valq[$];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp_pix(input int s);
        int t;
        t = s >>> SHIFT;
        if (t < 0) return 0;
        if (t > 255) return 255;
        return t;
    endfunction

    task automatic apply_taps();
        Tap0 = 8'(taps[0]); Tap1 = 8'(taps[1]); Tap2 = 8'(taps[2]); Tap3 = 8'(taps[3]);
        Tap4 = 8'(taps[4]); Tap5 = 8'(taps[5]); Tap6 = 8'(taps[6]);
    endtask

    task automatic model_reset();
        cnt = 0;
        for (int i = 0; i < 7; i++) mcoef[i] = 0;
        dueq.delete();
        valq.delete();
        last_sum = 0;
        prev_v = 0;
        prev_sum = 0;
    endtask

    // One clock: drive inputs, advance the model by one edge, compare every output.
    task automatic cyc(input bit we, input bit fs, input bit cwe, input int ca, input int cd);
        int acc;
        int exp_v;
        WE = we; Frame_Start = fs; Coef_WE = cwe; Coef_Addr = 3'(ca); Coef_Data = 8'(cd);
        @(posedge CLK);
        #1;
        edge_n++;
        if (cwe && ca != 7) mcoef[ca] = cd;
        if (fs) begin
            cnt = 0;
            dueq.delete();
            valq.delete();
        end
        if (we && cnt < IMG) cnt++;
        if (we) begin
            for (int i = 0; i < 7; i++)
                taps[i] = (fixed_tap >= 0) ? fixed_tap : int'($urandom_range(0, 255));
            apply_taps();
            if (cnt == IMG) begin
                acc = 0;
                for (int i = 0; i < 7; i++) acc += taps[i] * mcoef[i];
                dueq.push_back(edge_n + 3);
                valq.push_back(acc);
            end
        end
        exp_v = 0;
        if (dueq.size() > 0 && dueq[0] == edge_n) begin
            exp_v = 1;
            last_sum = valq.pop_front();
            void'(dueq.pop_front());
        end
        if (Out_Valid) ovs++;
        check("out_valid", int'(Out_Valid), exp_v);
        check("sum", int'($signed(Sum)), last_sum);
        check("fill_done", int'(Fill_Done), (cnt == IMG) ? 1 : 0);
`ifdef TAP7_PIXOUT_EN
        check("pix_valid", int'(Pix_Valid), prev_v);
        check("pix_out", int'(Pix_Out), clamp_pix(prev_sum));
`endif
        prev_v = exp_v;
        prev_sum = last_sum;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    // Coefficient loads wait for the pipeline to drain so each sum sees one coefficient set.
    task automatic load_coefs(input int c0, input int c1, input int c2, input int c3,
                              input int c4, input int c5, input int c6);
        int c [7];
        c = '{c0, c1, c2, c3, c4, c5, c6};
        while (dueq.size() > 0) idle(1);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, i, c[i]);
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        #1 CLR = 1'b0;
        #1;
        model_reset();
        check({tag, "_sum"}, int'($signed(Sum)), 0);
        check({tag, "_valid"}, int'(Out_Valid), 0);
        check({tag, "_fill"}, int'(Fill_Done), 0);
`ifdef TAP7_PIXOUT_EN
        check({tag, "_pix"}, int'(Pix_Out), 0);
        check({tag, "_pixv"}, int'(Pix_Valid), 0);
`endif
        @(posedge CLK);
        #2 CLR = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 7; i++) taps[i] = 0;
        model_reset();
        do_reset("reset");

        // Fill boundary with all coefficients 1, all taps 10
        load_coefs(1, 1, 1, 1, 1, 1, 1);
        fixed_tap = 10;
        ovs = 0;
        repeat (IMG - 1) cyc(1, 0, 0, 0, 0);
        check("fill_223", int'(Fill_Done), 0);
        check("novalid_223", ovs, 0);
        cyc(1, 0, 0, 0, 0);
        check("fill_224", int'(Fill_Done), 1);
        idle(2);
        check("early_valid", ovs, 0);
        idle(1);
        check("valid_3_after", int'(Out_Valid), 1);
        check("sum_70", int'($signed(Sum)), 70);
        idle(2);
        check("sum_hold", int'($signed(Sum)), 70);

        // Most negative single product
        load_coefs(0, 0, 0, -128, 0, 0, 0);
        fixed_tap = 255;
        cyc(1, 0, 0, 0, 0);
        idle(3);
        check("sum_neg", int'($signed(Sum)), -32640);

        // Streaming: 10 back-to-back strobes
        load_coefs($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                   $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                   $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                   $urandom_range(0, 255) - 128);
        fixed_tap = -1;
        ovs = 0;
        repeat (10) cyc(1, 0, 0, 0, 0);
        idle(3);
        check("stream_count", ovs, 10);

        // Random traffic with occasional coefficient writes (including address 7)
        for (int i = 0; i < 600; i++) begin
            bit we, fs, cwe;
            we  = ($urandom_range(0, 3) != 0);
            fs  = ($urandom_range(0, 199) == 0);
            cwe = (dueq.size() == 0) && ($urandom_range(0, 5) == 0);
            cyc(we, fs, cwe, $urandom_range(0, 7), $urandom_range(0, 255) - 128);
        end

        // Frame_Start together with WE on a full line
        repeat (IMG) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        ovs = 0;
        cyc(1, 1, 0, 0, 0);
        check("fs_fill", int'(Fill_Done), 0);
        idle(4);
        check("fs_suppressed", ovs, 0);
        repeat (IMG - 2) cyc(1, 0, 0, 0, 0);
        check("fs_count_222", int'(Fill_Done), 0);
        cyc(1, 0, 0, 0, 0);
        check("fs_count_refill", int'(Fill_Done), 1);

        // Clamp/shift cases
        load_coefs(8, 0, 0, 0, 0, 0, 0);
        fixed_tap = 125;
        cyc(1, 0, 0, 0, 0);
        idle(4);
        check("sum_1000", int'($signed(Sum)), 1000);
`ifdef TAP7_PIXOUT_EN
        check("pix_1000", int'(Pix_Out), 250);
`endif
        load_coefs(-5, 0, 0, 0, 0, 0, 0);
        fixed_tap = 1;
        cyc(1, 0, 0, 0, 0);
        idle(4);
        check("sum_m5", int'($signed(Sum)), -5);
`ifdef TAP7_PIXOUT_EN
        check("pix_m5", int'(Pix_Out), 0);
`endif
        load_coefs(16, 0, 0, 0, 0, 0, 0);
        fixed_tap = 125;
        cyc(1, 0, 0, 0, 0);
        idle(4);
        check("sum_2000", int'($signed(Sum)), 2000);
`ifdef TAP7_PIXOUT_EN
        check("pix_2000", int'(Pix_Out), 255);
`endif

        // Asynchronous reset mid-pipeline, then refill with cleared coefficients
        load_coefs(3, -7, 11, 5, -2, 9, 1);
        fixed_tap = -1;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        do_reset("midreset");
        ovs = 0;
        repeat (IMG - 1) cyc(1, 0, 0, 0, 0);
        idle(3);
        check("post_reset_novalid", ovs, 0);
        cyc(1, 0, 0, 0, 0);
        idle(3);
        check("post_reset_valid", ovs, 1);
        check("post_reset_sum", int'($signed(Sum)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tap7_mac.md
TAP7_MAC -- requirements
Module: tap7_mac

Interface
REQ-001 The block SHALL have parameter IMG_Width, default 224, meaning the line length in pixels, which is the shift depth of the upstream line buffer.
REQ-002 The block SHALL have parameter Datawidth, default 8, meaning the unsigned pixel width.
REQ-003 The block SHALL have parameter CoefWidth, default 8, meaning the signed coefficient width.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port CLR, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port WE, input, 1 bit: the same shift strobe that drives the upstream line buffer.
REQ-007 The block SHALL have ports Tap0..Tap6, input, Datawidth each: the line-buffer taps, where Tap0 is the oldest pixel.
REQ-008 The block SHALL have port Frame_Start, input, 1 bit: a synchronous restart of fill tracking.
REQ-009 The block SHALL have port Coef_WE, input, 1 bit: the coefficient write strobe.
REQ-010 The block SHALL have port Coef_Addr, input, 3 bits: the coefficient index 0..6.
REQ-011 The block SHALL have port Coef_Data, input, CoefWidth bits: signed coefficient write data.
REQ-012 The block SHALL have port Sum, output, Datawidth+CoefWidth+4 bits: the signed weighted sum.
REQ-013 The block SHALL have port Out_Valid, output, 1 bit: a one-cycle qualifier for Sum.
REQ-014 The block SHALL have port Fill_Done, output, 1 bit: high when the line buffer holds a full line.

Function
REQ-015 A 9-bit-or-wider fill counter SHALL increment on each edge with WE=1 and saturate at IMG_Width.
REQ-016 Fill_Done SHALL equal (counter == IMG_Width), registered.
REQ-017 A registered strobe cap_en SHALL be set at an edge where WE=1 and the post-increment count equals IMG_Width; it SHALL be 0 otherwise.
REQ-018 Stage 1 SHALL capture Tap0..Tap6 on the edge after a WE edge when cap_en=1, since the taps are stable after the shift.
REQ-019 Stage 2 SHALL register seven products, each signed(zero-extended Tap_i) x Coef_i, Datawidth+CoefWidth+1 bits.
REQ-020 Stage 3 SHALL register the sign-extended sum of the seven products into Sum, with no overflow possible at the specified width.
REQ-021 Out_Valid SHALL be high for exactly one cycle, 3 edges after the qualifying WE edge, with one valid per qualifying WE.
REQ-022 Sum SHALL hold its last value when Out_Valid=0.
REQ-023 Back-to-back WE pulses SHALL produce back-to-back Out_Valid pulses, i.e. full throughput with no stall.
REQ-024 Frame_Start=1 SHALL zero the counter and all in-flight valid bits on that edge; Sum is not cleared.
REQ-025 When Frame_Start and WE are both 1 on the same edge, the counter SHALL become 1, not 0.
REQ-026 A coefficient write with Coef_WE=1 SHALL update Coef[Coef_Addr] on that edge; Coef_Addr=7 SHALL be ignored.
REQ-027 A coefficient write SHALL affect only products formed on later edges; in-flight stage-3 data SHALL be unaffected.
REQ-028 The block SHALL apply no internal back-pressure; WE is never gated.

Reset
REQ-029 CLR=0 SHALL asynchronously clear the counter, Fill_Done, cap_en, all pipeline registers, Sum, Out_Valid, and all coefficients to 0.
REQ-030 Reset asserted mid-line SHALL discard the partial fill; after release, IMG_Width further WE pulses SHALL be needed before any Out_Valid.
REQ-031 Release of CLR SHALL take effect on the first CLK edge with CLR=1.

Configuration
REQ-032 Macro TAP7_PIXOUT_EN SHALL control an extra output stage.
REQ-033 When TAP7_PIXOUT_EN is defined, the block SHALL add parameter Shift (default 0), output Pix_Out (Datawidth), and output Pix_Valid. Pix_Out SHALL be Sum arithmetically shifted right by Shift and clamped to [0, 2^Datawidth-1], registered, making it one cycle after Out_Valid; Pix_Valid SHALL be Out_Valid delayed 1. Both SHALL reset to 0.
REQ-034 When TAP7_PIXOUT_EN is undefined, Pix_Out, Pix_Valid and Shift SHALL be absent and the logic SHALL be removed.

Verification
REQ-035 Fill: 223 WE pulses -> Out_Valid stays 0 and Fill_Done=0; the 224th WE -> Fill_Done=1, and Out_Valid=1 exactly 3 cycles after that edge.
REQ-036 Arithmetic: all Coef=1, all taps=10 -> Sum=70; Coef3=-128 and others 0, Tap3=255 -> Sum=-32640.
REQ-037 Streaming: 10 consecutive WE pulses after fill -> 10 consecutive Out_Valid pulses, each Sum matching a reference model.
REQ-038 Frame_Start together with WE at count 224 -> count=1, Fill_Done=0, in-flight Out_Valid suppressed.
REQ-039 CLR pulsed low mid-pipeline -> Sum=0 and Out_Valid=0 immediately, without waiting for a clock edge; coefficients read back as 0 (all-zero Sum).
REQ-040 With TAP7_PIXOUT_EN defined and Shift=2: Sum=1000 -> Pix_Out=250; Sum=-5 -> Pix_Out=0; Sum=2000 -> Pix_Out=255.
